// File: rtl/total_display.sv
// rtl/total_display.sv - 16-bit total to 5-digit BCD with multiplexed seven-segment scan
module total_display #(
    parameter int REFRESH_DIV = 27000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] total,
    output logic        busy,
    output logic [19:0] bcd,
    output logic [4:0]  an,
    output logic [6:0]  seg
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        state, state_nxt;
    logic [15:0]   last_val;
    logic [15:0]   bin;
    logic [19:0]   scratch;
    logic [19:0]   adj;
    logic [3:0]    iter;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [3:0]    digit;
    logic [4:0]    blank;
    logic [6:0]    seg_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (total != last_val) state_nxt = CONV;
            CONV:    if (iter == 4'd15)     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied before every shift of the double-dabble.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_val <= '0;
            bin      <= '0;
            scratch  <= '0;
            iter     <= '0;
            busy     <= 1'b0;
            bcd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (total != last_val) begin
                        bin      <= total;
                        last_val <= total;
                        scratch  <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    {scratch, bin} <= {adj[18:0], bin, 1'b0};
                    iter           <= iter + 4'd1;
                end
                DONE: begin
                    bcd  <= scratch;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A digit above the units is blank when it and everything above it is zero.
    always_comb begin
        blank[4] = (bcd[19:16] == 4'd0);
        blank[3] = blank[4] && (bcd[15:12] == 4'd0);
        blank[2] = blank[3] && (bcd[11:8]  == 4'd0);
        blank[1] = blank[2] && (bcd[7:4]   == 4'd0);
        blank[0] = 1'b0;
    end

    always_comb begin
        digit = 4'd0;
        case (idx)
            3'd0:    digit = bcd[3:0];
            3'd1:    digit = bcd[7:4];
            3'd2:    digit = bcd[11:8];
            3'd3:    digit = bcd[15:12];
            3'd4:    digit = bcd[19:16];
            default: digit = 4'd0;
        endcase
    end

    always_comb begin
        seg_nxt = 7'h7F;
        case (digit)
            4'd0:    seg_nxt = 7'h40;
            4'd1:    seg_nxt = 7'h79;
            4'd2:    seg_nxt = 7'h24;
            4'd3:    seg_nxt = 7'h30;
            4'd4:    seg_nxt = 7'h19;
            4'd5:    seg_nxt = 7'h12;
            4'd6:    seg_nxt = 7'h02;
            4'd7:    seg_nxt = 7'h78;
            4'd8:    seg_nxt = 7'h00;
            4'd9:    seg_nxt = 7'h10;
            default: seg_nxt = 7'h7F;
        endcase
        if (BLANK_LZ && idx <= 3'd4 && blank[idx])
            seg_nxt = 7'h7F;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
            an  <= 5'b11111;
            seg <= 7'h7F;
        end else begin
            if (cnt == CW'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            an  <= ~(5'b00001 << idx);
            seg <= seg_nxt;
        end
    end

endmodule
